// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: LFSR geometry, feedback taps, phase-shifter
// offsets and the pattern-sequencer state encoding.
package lbist_pkg;

    localparam int LFSR_W = 24;

    // Feedback taps of x^24+x^23+x^22+x^17+1 (bit indices into the LFSR).
    localparam int TAP_A = 23;
    localparam int TAP_B = 22;
    localparam int TAP_C = 21;
    localparam int TAP_D = 16;
    localparam logic [LFSR_W-1:0] TAP_MASK = (LFSR_W'(1) << TAP_A) | (LFSR_W'(1) << TAP_B)
                                           | (LFSR_W'(1) << TAP_C) | (LFSR_W'(1) << TAP_D);

    // Chain i is fed lfsr[i+PS_OFF0] ^ lfsr[i+PS_OFF1] ^ lfsr[i+PS_OFF2].
    localparam int PS_OFF0 = 0;
    localparam int PS_OFF1 = 8;
    localparam int PS_OFF2 = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } tpg_state_e;

endpackage

// File: rtl/lbist_lfsr.sv
// Fibonacci LFSR with synchronous reload and advance enable; reset and load
// both return it to SEED.
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int                WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [WIDTH-1:0] q
);

    logic fb;

    assign fb = ^(q & WIDTH'(TAP_MASK));

    // State register: load has priority over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= SEED;
        else if (load)  q <= SEED;
        else if (adv)   q <= {q[WIDTH-2:0], fb};
    end

    // An all-zero seed locks the LFSR at zero forever.
    a_seed_nonzero: assert property (@(posedge clk) SEED != '0);

endmodule

// File: rtl/lbist_tpg.sv
// LBIST test pattern generator: drives pseudo-random scan-in data through a
// phase shifter and sequences shift / capture / final unload for each run.
module lbist_tpg
    import lbist_pkg::*;
#(
    parameter int          N_CHAINS   = 7,
    parameter int          CHAIN_LEN  = 64,
    parameter int          N_PATTERNS = 1000,
    parameter int unsigned SEED       = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic [N_CHAINS-1:0]               scan_in,
    output logic                              scan_en,
    output logic                              eval_en,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(N_PATTERNS+1)-1:0]   pat_cnt
);

    localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PC_W = $clog2(N_PATTERNS + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PC_MAX  = PC_W'(N_PATTERNS);

    tpg_state_e        state, state_nxt;
    logic [SC_W-1:0]   sh_cnt;
    logic [PC_W-1:0]   pat_inc;
    logic              sh_last;
    logic              lfsr_load, lfsr_adv;
    logic [LFSR_W-1:0] lfsr;
    logic [N_CHAINS-1:0] ps;

    assign sh_last = (sh_cnt == SC_LAST);
    assign pat_inc = pat_cnt + PC_W'(1);

    lbist_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_W'(SEED))
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .adv   (lfsr_adv),
        .q     (lfsr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and phase outputs; start only matters in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        scan_en   = 1'b0;
        eval_en   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    lfsr_load = 1'b1;
                end
            end
            SHIFT: begin
                scan_en  = 1'b1;
                busy     = 1'b1;
                lfsr_adv = 1'b1;
                if (sh_last) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                eval_en   = 1'b1;
                busy      = 1'b1;
                state_nxt = (pat_inc == PC_MAX) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                scan_en  = 1'b1;
                busy     = 1'b1;
                lfsr_adv = 1'b1;
                if (sh_last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = SHIFT;
                    lfsr_load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift counter restarts every phase; pat_cnt counts captures and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cnt  <= '0;
            pat_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_cnt  <= '0;
                        pat_cnt <= '0;
                    end
                end
                SHIFT, UNLOAD: sh_cnt <= sh_last ? '0 : sh_cnt + SC_W'(1);
                CAPTURE: begin
                    sh_cnt <= '0;
                    if (pat_cnt != PC_MAX) pat_cnt <= pat_inc;
                end
                default: sh_cnt <= '0;
            endcase
        end
    end

    // Phase shifter: three-way XOR of the registered LFSR, gated by scan_en.
    always_comb begin
        ps      = N_CHAINS'((lfsr >> PS_OFF0) ^ (lfsr >> PS_OFF1) ^ (lfsr >> PS_OFF2));
        scan_in = scan_en ? ps : '0;
    end

endmodule

// File: tb/tb_lbist_tpg.sv
// Self-checking bench for lbist_tpg: per-cycle comparison against a trace
// built from the sequencing rules, with random start noise and resets.
module tb_lbist_tpg;

    localparam int          NC   = 7;
    localparam int          CL   = 4;
    localparam int          NP   = 2;
    localparam int unsigned SEED = 1000;
    localparam int          PCW  = $clog2(NP + 1);
    localparam int          TLEN = NP * (CL + 1) + CL;

    typedef struct {
        bit          se;
        bit          ee;
        bit [NC-1:0] si;
        int          pc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [NC-1:0] scan_in;
    logic          scan_en, eval_en, busy, done;
    logic [PCW-1:0] pat_cnt;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t trace[$];
    logic [63:0] busy_ref, busy_run;

    lbist_tpg #(
        .N_CHAINS   (NC),
        .CHAIN_LEN  (CL),
        .N_PATTERNS (NP),
        .SEED       (SEED)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .scan_in (scan_in),
        .scan_en (scan_en),
        .eval_en (eval_en),
        .busy    (busy),
        .done    (done),
        .pat_cnt (pat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference LFSR step: shift left, feed back parity of taps 23,22,21,16.
    function automatic bit [23:0] model_adv(input bit [23:0] s);
        bit fb;
        fb = s[23] ^ s[22] ^ s[21] ^ s[16];
        return (s << 1) | 24'(fb);
    endfunction

    function automatic bit [NC-1:0] model_phase(input bit [23:0] s);
        bit [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = s[i] ^ s[i+8] ^ s[i+16];
        return r;
    endfunction

    // Expected per-cycle outputs of one complete run, starting at first SHIFT.
    task automatic build_trace();
        bit [23:0] s;
        s = 24'(SEED);
        trace.delete();
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < CL; k++) begin
                trace.push_back('{se: 1'b1, ee: 1'b0, si: model_phase(s), pc: p});
                s = model_adv(s);
            end
            trace.push_back('{se: 1'b0, ee: 1'b1, si: '0, pc: p});
        end
        for (int k = 0; k < CL; k++) begin
            trace.push_back('{se: 1'b1, ee: 1'b0, si: model_phase(s), pc: NP});
            s = model_adv(s);
        end
    endtask

    task automatic chk_quiet(input string tag, input bit exp_done, input int exp_pc);
        chk({tag, ".busy"},    busy,    0);
        chk({tag, ".scan_en"}, scan_en, 0);
        chk({tag, ".eval_en"}, eval_en, 0);
        chk({tag, ".scan_in"}, scan_in, 0);
        chk({tag, ".done"},    done,    64'(exp_done));
        chk({tag, ".pat_cnt"}, pat_cnt, 64'(exp_pc));
    endtask

    // One run from IDLE/DONE; rst_at >= 0 aborts with reset at that trace cycle.
    task automatic run(input string tag, input int rst_at, input bit noisy,
                       output logic [63:0] bstream);
        bstream = '0;
        start = 1'b1;
        for (int k = 0; k < TLEN; k++) begin
            @(posedge clk); #1;
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bstream[k] = busy;
            chk($sformatf("%s.se%0d", tag, k),   scan_en, 64'(trace[k].se));
            chk($sformatf("%s.ee%0d", tag, k),   eval_en, 64'(trace[k].ee));
            chk($sformatf("%s.si%0d", tag, k),   scan_in, 64'(trace[k].si));
            chk($sformatf("%s.pc%0d", tag, k),   pat_cnt, 64'(trace[k].pc));
            chk($sformatf("%s.bsy%0d", tag, k),  busy,    1);
            chk($sformatf("%s.done%0d", tag, k), done,    0);
            if (k == 0) chk({tag, ".si_first"}, scan_in, 7'h6B);
            if (k == 1) chk({tag, ".si_second"}, scan_in, 7'h57);
            if (k == rst_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk_quiet({tag, ".rst"}, 1'b0, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        bstream[TLEN] = busy;
        chk_quiet({tag, ".fin"}, 1'b1, NP);
    endtask

    initial begin
        int  at;
        bit  in_done;
        build_trace();

        #2 rst_n = 1'b0;
        #10;
        chk_quiet("reset", 1'b0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_quiet("idle", 1'b0, 0);

        run("runA", -1, 1'b0, busy_ref);
        chk("busy_cycles", 64'($countones(busy_ref)), TLEN);

        repeat ($urandom_range(1, 5)) begin
            @(posedge clk); #1;
            chk_quiet("hold", 1'b1, NP);
        end

        run("runB", -1, 1'b1, busy_run);
        chk("busy_stream_B", busy_run, busy_ref);

        run("runC", CL + 1 + 2, 1'b1, busy_run);
        @(posedge clk); #1;
        chk_quiet("after_rst", 1'b0, 0);

        run("runD", -1, 1'b0, busy_run);
        chk("busy_stream_D", busy_run, busy_ref);

        for (int r = 0; r < 8; r++) begin
            at = $urandom_range(0, TLEN + 4);
            in_done = (at >= TLEN);
            run($sformatf("rnd%0d", r), in_done ? -1 : at, 1'b1, busy_run);
            if (in_done) chk($sformatf("rnd%0d.stream", r), busy_run, busy_ref);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                chk_quiet($sformatf("rnd%0d.wait", r), in_done, in_done ? NP : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
